dti_rsp_pkt_fifo: RTL and testbench
===================================

Name: dti_rsp_pkt_fifo

Overview:
Store-and-forward packet buffer for the DTI response stream. It captures beats from the DTI agent and presents them to the NoC converter's rsp_t* input only once a complete packet (up to tlast) is held. This prevents NoC response packets from stalling mid-packet on upstream bubbles. A cut-through fallback lets packets longer than the buffer drain without deadlock.

Parameters:
DEPTH, 16, number of beat entries; power of two, >= 2
PTR_W, $clog2(DEPTH), read/write pointer width (derived, not overridden)
CNT_W, $clog2(DEPTH)+1, width of occupancy and packet counters (derived)

Ports:
clk  in  1  single clock, all state on rising edge
rst_n  in  1  asynchronous, active-low reset
in_tvalid  in  1  upstream beat valid
in_tready  out  1  upstream ready; equals !full
in_tdata  in  80  DTI beat data
in_tkeep  in  10  byte enables
in_tlast  in  1  last beat of packet
in_ttid  in  6  transaction/source id
out_tvalid  out  1  beat valid towards converter rsp_tvalid
out_tready  in  1  converter ready (rsp_tready)
out_tdata  out  80  head beat data
out_tkeep  out  10  head beat keep
out_tlast  out  1  head beat last
out_ttid  out  6  head beat id
occupancy  out  CNT_W  beats stored, 0..DEPTH
pkt_cnt  out  CNT_W  complete packets stored

Behaviour:
- Reset (async assert, sync deassert use): wr_ptr=rd_ptr=0, occupancy=0, pkt_cnt=0, cut_thru=0. Outputs: out_tvalid=0, in_tready=1, out_t* data=0 (storage array not reset, output masked).
- Write: on in_tvalid && in_tready, store {tdata,tkeep,tlast,ttid} at wr_ptr; wr_ptr wraps DEPTH-1 -> 0.
- Read: on out_tvalid && out_tready, rd_ptr advances with the same wrap. Head data is driven combinationally from the array at rd_ptr.
- full = (occupancy==DEPTH); empty = (occupancy==0).
- Simultaneous read and write when full: in_tready=0, so only the read occurs.
- Simultaneous read and write when empty: out_tvalid=0, so only the write occurs.
- occupancy: +1 on write only, -1 on read only, unchanged on both or neither.
- pkt_cnt: +1 on write of a tlast beat, -1 on read of a tlast beat, unchanged when both or neither occur.
- out_tvalid = !empty && (pkt_cnt!=0 || cut_thru).
- cut_thru: set when full && pkt_cnt==0 (single oversize packet fills the buffer). Cleared on the cycle a tlast beat is read. While set, beats forward as soon as stored (cut-through).
- Latency: tlast written in cycle N -> pkt_cnt and out_tvalid high in N+1, i.e. one-cycle minimum store-to-forward. There is no combinational path from in_* to out_*.
- AXI-S rules:
  - out_t* hold stable while out_tvalid && !out_tready.
  - out_tvalid never drops without a handshake, since pkt_cnt/cut_thru only fall on a read.
  - in_tready does not depend on in_tvalid.
- Packet integrity: beats are never reordered or dropped. ttid is passed through per beat unmodified.
- Reset mid-packet: all buffered beats are discarded and out_tvalid drops asynchronously. The upstream agent is reset in the same domain.

Decomposition:
- dti_pack gains:
  - DTI_DATA_W=80, DTI_KEEP_W=10, DTI_TID_W=6
  - typedef struct packed {tdata; tkeep; tlast; ttid} dti_beat_t (97 bits)
- The converter and this block share these constants.
- One natural sub-module: dti_sync_fifo (parameterised DEPTH, dti_beat_t payload, exports occupancy/full/empty). The packet counter and cut_thru control stay in dti_rsp_pkt_fifo.

Test Plan:
1. Three-beat packet tid=5 with out_tready=1, tlast on beat 3 -> out_tvalid stays 0 until the cycle after beat 3 is written, then 3 beats out back-to-back with tid=5 and tkeep intact.
2. Upstream bubble: beats 1 and 2, 4 idle cycles, then beat 3 (tlast) -> no output during the bubble; packet emitted contiguously afterwards.
3. Backpressure: 16 one-beat packets with out_tready=0 -> occupancy=16, pkt_cnt=16, in_tready=0. Release out_tready -> 16 beats in order, in_tready=1 after the first read.
4. Oversize packet: 20 beats, tlast on 20, DEPTH=16 -> at full with pkt_cnt=0, cut_thru=1 and out_tvalid=1. All 20 beats arrive in order; cut_thru=0 after tlast is read.
5. Steady-state concurrent read and write at occupancy=8 -> occupancy and pkt_cnt unchanged; no lost or duplicated beats against a scoreboard.
6. rst_n asserted with 5 beats buffered and out_tready=0 -> out_tvalid=0, occupancy=0, pkt_cnt=0 immediately. After release, a new packet passes normally.

Source files
------------

// File: rtl/dti_rsp_pkt_fifo_pkg.sv
// Shared DTI response beat definitions, used by the packet buffer and the NoC converter.
package dti_rsp_pkt_fifo_pkg;

  localparam int DTI_DATA_W = 80;
  localparam int DTI_KEEP_W = 10;
  localparam int DTI_TID_W  = 6;

  typedef struct packed {
    logic [DTI_DATA_W-1:0] tdata;
    logic [DTI_KEEP_W-1:0] tkeep;
    logic                  tlast;
    logic [DTI_TID_W-1:0]  ttid;
  } dti_beat_t;

  localparam int DTI_BEAT_W = $bits(dti_beat_t);

  // Forces a beat to all-zero when it is not being presented.
  function automatic dti_beat_t dti_beat_mask(input dti_beat_t beat, input logic en);
    return en ? beat : '0;
  endfunction

endpackage

// File: rtl/dti_sync_fifo.sv
// Single-clock beat FIFO with occupancy tracking; storage is not reset, only pointers/count.
module dti_sync_fifo
  import dti_rsp_pkt_fifo_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en_i,
  input  dti_beat_t                  wr_beat_i,
  input  logic                       rd_en_i,
  output dti_beat_t                  rd_beat_o,
  output logic [$clog2(DEPTH):0]     occupancy_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  dti_beat_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             wr_ok, rd_ok;

  assign full_o      = (occ_q == CNT_W'(DEPTH));
  assign empty_o     = (occ_q == '0);
  assign occupancy_o = occ_q;
  assign rd_beat_o   = mem_q[rd_ptr_q];

  // Guard here too so a misbehaving parent cannot corrupt the pointers.
  assign wr_ok = wr_en_i && !full_o;
  assign rd_ok = rd_en_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (wr_ok) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    if (rd_ok) rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    case ({wr_ok, rd_ok})
      2'b10:   occ_d = occ_q + CNT_W'(1);
      2'b01:   occ_d = occ_q - CNT_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_beat_i;
  end

endmodule

// File: rtl/dti_rsp_pkt_fifo.sv
// Store-and-forward DTI response packet buffer with cut-through fallback for packets
// longer than the buffer. Output only starts once a whole packet (tlast) is held.
module dti_rsp_pkt_fifo
  import dti_rsp_pkt_fifo_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_tvalid,
  output logic                      in_tready,
  input  logic [DTI_DATA_W-1:0]     in_tdata,
  input  logic [DTI_KEEP_W-1:0]     in_tkeep,
  input  logic                      in_tlast,
  input  logic [DTI_TID_W-1:0]      in_ttid,
  output logic                      out_tvalid,
  input  logic                      out_tready,
  output logic [DTI_DATA_W-1:0]     out_tdata,
  output logic [DTI_KEEP_W-1:0]     out_tkeep,
  output logic                      out_tlast,
  output logic [DTI_TID_W-1:0]      out_ttid,
  output logic [$clog2(DEPTH):0]    occupancy,
  output logic [$clog2(DEPTH):0]    pkt_cnt
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Handshake: a beat moves on a port only in a cycle where valid && ready are both
  // high at the rising edge; in_tready depends only on fill level, never on in_tvalid.
  dti_beat_t        in_beat, head_beat, out_beat;
  logic             full, empty;
  logic             wr_fire, rd_fire;
  logic             wr_last, rd_last;
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic             cut_thru_q, cut_thru_d;

  assign in_beat = '{tdata: in_tdata, tkeep: in_tkeep, tlast: in_tlast, ttid: in_ttid};

  assign in_tready  = !full;
  assign out_tvalid = !empty && ((pkt_cnt_q != '0) || cut_thru_q);
  assign wr_fire    = in_tvalid && in_tready;
  assign rd_fire    = out_tvalid && out_tready;
  assign wr_last    = wr_fire && in_tlast;
  assign rd_last    = rd_fire && head_beat.tlast;

  dti_sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en_i     (wr_fire),
    .wr_beat_i   (in_beat),
    .rd_en_i     (rd_fire),
    .rd_beat_o   (head_beat),
    .occupancy_o (occupancy),
    .full_o      (full),
    .empty_o     (empty)
  );

  always_comb begin
    pkt_cnt_d  = pkt_cnt_q;
    cut_thru_d = cut_thru_q;
    case ({wr_last, rd_last})
      2'b10:   pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
      2'b01:   pkt_cnt_d = pkt_cnt_q - CNT_W'(1);
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
    // A full buffer with no complete packet can only be one oversize packet:
    // stream it out rather than wait for a tlast that can never be accepted.
    if (rd_last)                           cut_thru_d = 1'b0;
    else if (full && (pkt_cnt_q == '0))    cut_thru_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_q  <= '0;
      cut_thru_q <= 1'b0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      cut_thru_q <= cut_thru_d;
    end
  end

  assign pkt_cnt = pkt_cnt_q;

  // Storage is not reset, so the head is masked to keep the outputs clean when idle.
  assign out_beat  = dti_beat_mask(head_beat, out_tvalid);
  assign out_tdata = out_beat.tdata;
  assign out_tkeep = out_beat.tkeep;
  assign out_tlast = out_beat.tlast;
  assign out_ttid  = out_beat.ttid;

endmodule

// File: tb/tb_dti_rsp_pkt_fifo.sv
// Bench for the DTI response packet buffer: randomized beats checked against a queue model.
module tb_dti_rsp_pkt_fifo;
  import dti_rsp_pkt_fifo_pkg::*;

  localparam int DEPTH = 16;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  in_tvalid = 1'b0;
  logic                  in_tready;
  logic [DTI_DATA_W-1:0] in_tdata = '0;
  logic [DTI_KEEP_W-1:0] in_tkeep = '0;
  logic                  in_tlast = 1'b0;
  logic [DTI_TID_W-1:0]  in_ttid = '0;
  logic                  out_tvalid;
  logic                  out_tready = 1'b0;
  logic [DTI_DATA_W-1:0] out_tdata;
  logic [DTI_KEEP_W-1:0] out_tkeep;
  logic                  out_tlast;
  logic [DTI_TID_W-1:0]  out_ttid;
  logic [CNT_W-1:0]      occupancy;
  logic [CNT_W-1:0]      pkt_cnt;

  dti_rsp_pkt_fifo #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_tvalid  (in_tvalid),
    .in_tready  (in_tready),
    .in_tdata   (in_tdata),
    .in_tkeep   (in_tkeep),
    .in_tlast   (in_tlast),
    .in_ttid    (in_ttid),
    .out_tvalid (out_tvalid),
    .out_tready (out_tready),
    .out_tdata  (out_tdata),
    .out_tkeep  (out_tkeep),
    .out_tlast  (out_tlast),
    .out_ttid   (out_ttid),
    .occupancy  (occupancy),
    .pkt_cnt    (pkt_cnt)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Reference model: beats currently held, plus the cut-through flag.
  dti_beat_t exp_q[$];
  logic      exp_cut = 1'b0;
  int        checks = 0;
  int        failures = 0;
  logic      wr_fire, rd_fire;
  dti_beat_t rd_beat;

  function automatic int count_pkts();
    int n = 0;
    foreach (exp_q[i]) if (exp_q[i].tlast) n++;
    return n;
  endfunction

  function automatic dti_beat_t rand_beat(input logic [DTI_TID_W-1:0] tid, input logic last);
    dti_beat_t b;
    b.tdata = {16'($urandom), $urandom, $urandom};
    b.tkeep = 10'($urandom_range(1, 1023));
    b.tlast = last;
    b.ttid  = tid;
    return b;
  endfunction

  // Driver + scoreboard: one clock cycle. Inputs are applied just after a rising edge,
  // outputs are compared with the model on the falling edge, model advances after the edge.
  task automatic step(input logic vld, input dti_beat_t b, input logic rdy);
    logic      exp_rdy, exp_vld;
    int        npk;
    logic      was_full;
    dti_beat_t obs, head;
    in_tvalid  = vld;
    in_tdata   = b.tdata;
    in_tkeep   = b.tkeep;
    in_tlast   = b.tlast;
    in_ttid    = b.ttid;
    out_tready = rdy;
    @(negedge clk);
    npk      = count_pkts();
    was_full = (exp_q.size() == DEPTH);
    exp_rdy  = (exp_q.size() < DEPTH);
    exp_vld  = (exp_q.size() != 0) && (npk != 0 || exp_cut);
    checks++;
    if (in_tready !== exp_rdy) begin
      failures++;
      $display("FAIL sb_in_tready: got %b exp %b t=%0t", in_tready, exp_rdy, $time);
    end
    checks++;
    if (out_tvalid !== exp_vld) begin
      failures++;
      $display("FAIL sb_out_tvalid: got %b exp %b t=%0t", out_tvalid, exp_vld, $time);
    end
    checks++;
    if (occupancy !== CNT_W'(exp_q.size())) begin
      failures++;
      $display("FAIL sb_occupancy: got %0d exp %0d t=%0t", occupancy, exp_q.size(), $time);
    end
    checks++;
    if (pkt_cnt !== CNT_W'(npk)) begin
      failures++;
      $display("FAIL sb_pkt_cnt: got %0d exp %0d t=%0t", pkt_cnt, npk, $time);
    end
    obs = {out_tdata, out_tkeep, out_tlast, out_ttid};
    checks++;
    if (exp_vld) begin
      if (obs !== exp_q[0]) begin
        failures++;
        $display("FAIL sb_head_beat: got %h exp %h t=%0t", obs, exp_q[0], $time);
      end
    end else if (obs !== '0) begin
      failures++;
      $display("FAIL sb_idle_mask: got %h exp 0 t=%0t", obs, $time);
    end
    wr_fire = vld && exp_rdy;
    rd_fire = exp_vld && rdy;
    rd_beat = obs;
    @(posedge clk);
    #1;
    head = '0;
    if (rd_fire) head = exp_q.pop_front();
    if (rd_fire && head.tlast) exp_cut = 1'b0;
    else if (was_full && npk == 0) exp_cut = 1'b1;
    if (wr_fire) exp_q.push_back(b);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, '0, rdy);
  endtask

  task automatic drain();
    int budget = 200;
    while (exp_q.size() != 0 && budget > 0) begin
      idle(1'b1);
      budget--;
    end
    checks++;
    if (occupancy !== '0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: occupancy %0d model %0d", occupancy, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_tvalid !== 1'b0 || in_tready !== 1'b1) begin
      failures++;
      $display("FAIL reset_handshake: got valid %b ready %b exp 0 1", out_tvalid, in_tready);
    end
    checks++;
    if (occupancy !== '0 || pkt_cnt !== '0) begin
      failures++;
      $display("FAIL reset_counts: got occ %0d pkt %0d exp 0 0", occupancy, pkt_cnt);
    end
    checks++;
    if ({out_tdata, out_tkeep, out_tlast, out_ttid} !== '0) begin
      failures++;
      $display("FAIL reset_out_data: got %h exp 0", {out_tdata, out_tkeep, out_tlast, out_ttid});
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_packet();
    dti_beat_t b [3];
    for (int i = 0; i < 3; i++) b[i] = rand_beat(6'd5, i == 2);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, b[i], 1'b1);
      checks++;
      if (out_tvalid !== (i == 2)) begin
        failures++;
        $display("FAIL single_fwd_latency: beat %0d got valid %b exp %b", i, out_tvalid, i == 2);
      end
    end
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      checks++;
      if (!rd_fire || rd_beat.ttid !== 6'd5 || rd_beat.tkeep !== b[i].tkeep) begin
        failures++;
        $display("FAIL single_out_beat: beat %0d got fire %b tid %0d keep %h exp 1 5 %h",
                 i, rd_fire, rd_beat.ttid, rd_beat.tkeep, b[i].tkeep);
      end
    end
  endtask

  task automatic test_bubble();
    logic [DTI_TID_W-1:0] tid = 6'($urandom);
    step(1'b1, rand_beat(tid, 1'b0), 1'b1);
    step(1'b1, rand_beat(tid, 1'b0), 1'b1);
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      checks++;
      if (rd_fire || out_tvalid !== 1'b0) begin
        failures++;
        $display("FAIL bubble_no_output: cycle %0d got valid %b exp 0", i, out_tvalid);
      end
    end
    step(1'b1, rand_beat(tid, 1'b1), 1'b1);
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      checks++;
      if (rd_fire !== 1'b1) begin
        failures++;
        $display("FAIL bubble_contiguous: beat %0d got fire %b exp 1", i, rd_fire);
      end
    end
  endtask

  task automatic test_backpressure();
    int got = 0;
    for (int i = 0; i < DEPTH; i++) step(1'b1, rand_beat(6'(i), 1'b1), 1'b0);
    checks++;
    if (occupancy !== CNT_W'(DEPTH) || pkt_cnt !== CNT_W'(DEPTH) || in_tready !== 1'b0) begin
      failures++;
      $display("FAIL bp_full: got occ %0d pkt %0d ready %b exp 16 16 0", occupancy, pkt_cnt, in_tready);
    end
    idle(1'b1);
    if (rd_fire) got++;
    checks++;
    if (in_tready !== 1'b1) begin
      failures++;
      $display("FAIL bp_ready_after_read: got %b exp 1", in_tready);
    end
    for (int i = 0; i < DEPTH + 4; i++) begin
      idle(1'b1);
      if (rd_fire) got++;
    end
    checks++;
    if (got != DEPTH) begin
      failures++;
      $display("FAIL bp_read_count: got %0d exp %0d", got, DEPTH);
    end
  endtask

  task automatic test_oversize();
    dti_beat_t b [20];
    dti_beat_t cur;
    int idx = 0, got = 0, budget = 120;
    for (int i = 0; i < 20; i++) b[i] = rand_beat(6'd9, i == 19);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, b[idx], 1'b0);
      if (wr_fire) idx++;
    end
    checks++;
    if (occupancy !== CNT_W'(DEPTH) || pkt_cnt !== '0) begin
      failures++;
      $display("FAIL over_full: got occ %0d pkt %0d exp 16 0", occupancy, pkt_cnt);
    end
    idle(1'b0);
    checks++;
    if (dut.cut_thru_q !== 1'b1 || out_tvalid !== 1'b1) begin
      failures++;
      $display("FAIL over_cut_set: got cut %b valid %b exp 1 1", dut.cut_thru_q, out_tvalid);
    end
    while ((idx < 20 || got < 20) && budget > 0) begin
      cur = (idx < 20) ? b[idx] : '0;
      step(idx < 20, cur, 1'b1);
      budget--;
      if (wr_fire) idx++;
      if (rd_fire) begin
        checks++;
        if (rd_beat !== b[got]) begin
          failures++;
          $display("FAIL over_order: beat %0d got %h exp %h", got, rd_beat, b[got]);
        end
        if (rd_beat.tlast) begin
          checks++;
          if (dut.cut_thru_q !== 1'b0) begin
            failures++;
            $display("FAIL over_cut_clear: got %b exp 0", dut.cut_thru_q);
          end
        end
        got++;
      end
    end
    checks++;
    if (got != 20) begin
      failures++;
      $display("FAIL over_count: got %0d exp 20", got);
    end
  endtask

  task automatic test_concurrent();
    int rd_n = 0, wr_n = 0;
    for (int i = 0; i < 8; i++) step(1'b1, rand_beat(6'(i), 1'b1), 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, rand_beat(6'($urandom), (i % 2 == 1) ? 1'b1 : 1'($urandom_range(0, 1))), 1'b1);
      if (wr_fire) wr_n++;
      if (rd_fire) rd_n++;
      checks++;
      if (occupancy !== CNT_W'(8)) begin
        failures++;
        $display("FAIL conc_occupancy: cycle %0d got %0d exp 8", i, occupancy);
      end
    end
    checks++;
    if (rd_n != 40 || wr_n != 40) begin
      failures++;
      $display("FAIL conc_rates: got rd %0d wr %0d exp 40 40", rd_n, wr_n);
    end
    drain();
  endtask

  task automatic test_random();
    int budget = 100;
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0),
           rand_beat(6'($urandom), $urandom_range(0, 4) == 0),
           1'($urandom_range(0, 2) != 0));
    wr_fire = 1'b0;
    while (!wr_fire && budget > 0) begin
      step(1'b1, rand_beat(6'($urandom), 1'b1), 1'b1);
      budget--;
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int got = 0;
    for (int i = 0; i < 5; i++) step(1'b1, rand_beat(6'(i), 1'b1), 1'b0);
    checks++;
    if (out_tvalid !== 1'b1 || occupancy !== CNT_W'(5)) begin
      failures++;
      $display("FAIL rmid_before: got valid %b occ %0d exp 1 5", out_tvalid, occupancy);
    end
    in_tvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_tvalid !== 1'b0 || occupancy !== '0 || pkt_cnt !== '0) begin
      failures++;
      $display("FAIL rmid_async: got valid %b occ %0d pkt %0d exp 0 0 0", out_tvalid, occupancy, pkt_cnt);
    end
    exp_q.delete();
    exp_cut = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, rand_beat(6'd17, 1'b0), 1'b1);
    step(1'b1, rand_beat(6'd17, 1'b1), 1'b1);
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      if (rd_fire) got++;
    end
    checks++;
    if (got != 2) begin
      failures++;
      $display("FAIL rmid_after: got %0d beats exp 2", got);
    end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_bubble();
    test_backpressure();
    test_oversize();
    test_concurrent();
    test_random();
    test_reset_mid();
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
